// File: rtl/fu_pkg.sv
// Shared constants for the FPU functional-unit blocks.
// Holds the default fraction/exponent geometry and the fraction value
// that a rounding overflow renormalizes to.
package fu_pkg;

  // Default geometry: 7 fraction bytes hold a 53-bit mantissa plus padding.
  localparam int FU_FRAC_BYTES = 7;
  localparam int FU_EXP_W      = 13;
  localparam int FU_FRAC_W     = 8 * FU_FRAC_BYTES;

  // After a carry out of the MSB the sum is all zeros; the renormalized
  // fraction is 1.000... (bit 0 is the MSB in the [0:W-1] numbering).
  localparam logic [0:FU_FRAC_W-1] FU_OVF_FRAC = {1'b1, {(FU_FRAC_W-1){1'b0}}};

endpackage

// File: rtl/fu_loc8inc.sv
// Local 8-bit incrementer section used in the carry-select fraction adder.
// Produces the byte plus ci_b and the byte plus ci, and an active-low
// carry-out of the ci sum. With ci=1, ci_b=0 the outputs are the
// "no carry in" and "carry in" candidates, and ~co_b flags an all-ones byte.
module fu_loc8inc (
  input  logic [0:7] d,
  input  logic       ci,
  input  logic       ci_b,
  output logic [0:7] s0,
  output logic [0:7] s1,
  output logic       co_b
);

  assign s0   = d + {7'b0, ci_b};
  assign s1   = d + {7'b0, ci};
  // Carry out of d+ci happens only when every bit of d is set.
  assign co_b = ~(ci & (&d));

endmodule

// File: rtl/fu_rnd_inc.sv
// Two-stage rounding incrementer for the FPU round stage.
// ex1 registers the operand; the ex1->ex2 path adds the round-up bit with
// per-byte incrementers and a global carry-select, renormalizes on a carry
// out of the MSB, and bumps the exponent. ex2 registers drive the outputs.
module fu_rnd_inc
  import fu_pkg::*;
#(
  parameter  int NB = FU_FRAC_BYTES,
  parameter  int EW = FU_EXP_W,
  localparam int W  = 8 * NB
) (
  input  logic          nclk,
  input  logic          rst_b,
  input  logic          i_vld,
  input  logic [0:W-1]  i_frac,
  input  logic          i_inc,
  input  logic [0:EW-1] i_exp,
  input  logic          i_stall,
  input  logic          i_flush,
  output logic          o_vld,
  output logic [0:W-1]  o_frac,
  output logic [0:EW-1] o_exp,
  output logic          o_ovf
);

  // Renormalized fraction for this instance width: MSB set, rest clear.
  localparam logic [0:W-1] OVF_FRAC = {FU_OVF_FRAC[0], {(W-1){1'b0}}};

  // ex1 stage state
  logic          v1;
  logic [0:W-1]  frac1;
  logic          inc1;
  logic [0:EW-1] exp1;

  // Per-byte candidates and carry-select wiring
  logic [0:7]    s0 [NB];
  logic [0:7]    s1 [NB];
  logic [0:NB-1] co_b;
  logic [0:NB-1] allone;
  logic [0:NB-1] carry;
  logic [0:W-1]  frac_sum;

  // ex2 next-state values
  logic          ovf;
  logic [0:W-1]  frac_res;
  logic [0:EW-1] exp_res;

  // ex1 register: flush kills the valid bit only, stall holds everything.
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      v1    <= 1'b0;
      frac1 <= '0;
      inc1  <= 1'b0;
      exp1  <= '0;
    end else if (i_flush) begin
      v1 <= 1'b0;
    end else if (!i_stall) begin
      v1    <= i_vld;
      frac1 <= i_frac;
      inc1  <= i_inc;
      exp1  <= i_exp;
    end
  end

  // One local incrementer per byte; byte 0 is the most significant.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    fu_loc8inc u_loc8inc (
      .d    (frac1[8*gi +: 8]),
      .ci   (1'b1),
      .ci_b (1'b0),
      .s0   (s0[gi]),
      .s1   (s1[gi]),
      .co_b (co_b[gi])
    );

    assign allone[gi] = ~co_b[gi];

    // Carry into a byte: round-up requested and every less significant
    // byte is all ones. The LSB byte takes the round-up bit directly.
    if (gi == NB-1) begin : g_lsb
      assign carry[gi] = inc1;
    end else begin : g_upper
      assign carry[gi] = inc1 & (&allone[gi+1:NB-1]);
    end

    assign frac_sum[8*gi +: 8] = carry[gi] ? s1[gi] : s0[gi];
  end

  // Overflow, renormalization and exponent adjust (exponent wraps).
  always_comb begin
    ovf      = inc1 & (&allone);
    frac_res = frac_sum;
    exp_res  = exp1;
    if (ovf) begin
      frac_res = OVF_FRAC;
      exp_res  = exp1 + EW'(1);
    end
  end

  // ex2 register: drives the outputs; flush clears valid, stall holds.
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      o_vld  <= 1'b0;
      o_frac <= '0;
      o_exp  <= '0;
      o_ovf  <= 1'b0;
    end else if (i_flush) begin
      o_vld <= 1'b0;
    end else if (!i_stall) begin
      o_vld  <= v1;
      o_frac <= frac_res;
      o_exp  <= exp_res;
      o_ovf  <= ovf;
    end
  end

endmodule

// File: tb/tb_fu_rnd_inc.sv
// Self-checking bench for fu_rnd_inc: directed scenarios followed by a
// randomized stream, checked against a transaction-level reference model.
module tb_fu_rnd_inc;

  localparam int NB = 7;
  localparam int W  = 8 * NB;
  localparam int EW = 13;

  logic          nclk = 1'b0;
  logic          rst_b = 1'b0;
  logic          i_vld = 1'b0;
  logic [W-1:0]  i_frac = '0;
  logic          i_inc = 1'b0;
  logic [EW-1:0] i_exp = '0;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_vld;
  logic [W-1:0]  o_frac;
  logic [EW-1:0] o_exp;
  logic          o_ovf;

  fu_rnd_inc #(.NB(NB), .EW(EW)) dut (
    .nclk    (nclk),
    .rst_b   (rst_b),
    .i_vld   (i_vld),
    .i_frac  (i_frac),
    .i_inc   (i_inc),
    .i_exp   (i_exp),
    .i_stall (i_stall),
    .i_flush (i_flush),
    .o_vld   (o_vld),
    .o_frac  (o_frac),
    .o_exp   (o_exp),
    .o_ovf   (o_ovf)
  );

  always #5 nclk = ~nclk;

  typedef struct packed {
    logic [W-1:0]  frac;
    logic [EW-1:0] exp;
    logic          ovf;
  } res_t;

  res_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: fraction + round bit as a plain integer sum; a carry past
  // the MSB renormalizes to 1.000... and increments the exponent.
  function automatic res_t ref_model(input logic [W-1:0] f, input logic inc, input logic [EW-1:0] e);
    logic [W:0] s;
    res_t r;
    s = {1'b0, f} + (W+1)'(inc);
    if (s[W]) begin
      r.frac = '0;
      r.frac[W-1] = 1'b1;
      r.exp  = EW'(e + 1);
      r.ovf  = 1'b1;
    end else begin
      r.frac = s[W-1:0];
      r.exp  = e;
      r.ovf  = 1'b0;
    end
    return r;
  endfunction

  // One clock: drive inputs, pass an edge, then check what the edge did.
  task automatic cycle(input logic vld, input logic [W-1:0] f, input logic inc,
                       input logic [EW-1:0] e, input logic stall, input logic flush);
    res_t exp_r;
    res_t prev;
    logic prev_vld;
    logic acc;
    i_vld   = vld;
    i_frac  = f;
    i_inc   = inc;
    i_exp   = e;
    i_stall = stall;
    i_flush = flush;
    acc      = vld & ~stall & ~flush;
    prev_vld = o_vld;
    prev     = {o_frac, o_exp, o_ovf};
    @(posedge nclk);
    #1;
    if (flush) begin
      q.delete();
      check("flush_vld", 64'(o_vld), 64'd0);
    end else if (stall) begin
      check("stall_vld",  64'(o_vld),  64'(prev_vld));
      check("stall_frac", 64'(o_frac), 64'(prev.frac));
      check("stall_exp",  64'(o_exp),  64'(prev.exp));
      check("stall_ovf",  64'(o_ovf),  64'(prev.ovf));
    end else if (q.size() > 0) begin
      exp_r = q.pop_front();
      check("out_vld",  64'(o_vld),  64'd1);
      check("out_frac", 64'(o_frac), 64'(exp_r.frac));
      check("out_exp",  64'(o_exp),  64'(exp_r.exp));
      check("out_ovf",  64'(o_ovf),  64'(exp_r.ovf));
      $display("txn out frac=%h exp=%h ovf=%b", o_frac, o_exp, o_ovf);
    end else begin
      check("idle_vld", 64'(o_vld), 64'd0);
    end
    if (acc) q.push_back(ref_model(f, inc, e));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rf;
    logic [W-1:0] ones;

    // Reset state
    #12;
    check("rst_vld",  64'(o_vld),  64'd0);
    check("rst_frac", 64'(o_frac), 64'd0);
    check("rst_exp",  64'(o_exp),  64'd0);
    check("rst_ovf",  64'(o_ovf),  64'd0);
    rst_b = 1'b1;
    @(posedge nclk);
    #1;

    // Carry across one byte boundary
    cycle(1'b1, 56'h00000000_0000FF, 1'b1, 13'h3FF, 1'b0, 1'b0);
    idle();
    check("tp1_frac", 64'(o_frac), 64'h100);
    check("tp1_exp",  64'(o_exp),  64'h3FF);
    check("tp1_ovf",  64'(o_ovf),  64'd0);

    // Full overflow: renormalize and bump exponent
    cycle(1'b1, 56'hFFFFFFFF_FFFFFF, 1'b1, 13'h3FF, 1'b0, 1'b0);
    idle();
    check("tp2_frac", 64'(o_frac), 64'h80000000_000000);
    check("tp2_exp",  64'(o_exp),  64'h400);
    check("tp2_ovf",  64'(o_ovf),  64'd1);

    // Exponent wraps with no saturation
    cycle(1'b1, 56'hFFFFFFFF_FFFFFF, 1'b1, 13'h1FFF, 1'b0, 1'b0);
    idle();
    check("tp3_exp", 64'(o_exp), 64'h0);
    check("tp3_ovf", 64'(o_ovf), 64'd1);

    // inc=0 passes through
    cycle(1'b1, 56'hFFFFFFFF_FFFFFF, 1'b0, 13'h0123, 1'b0, 1'b0);
    idle();
    check("pass_frac", 64'(o_frac), 64'hFFFFFFFF_FFFFFF);
    check("pass_ovf",  64'(o_ovf),  64'd0);

    // Stream of 4 with a 3-cycle stall after the second op
    cycle(1'b1, 56'h11, 1'b1, 13'h10, 1'b0, 1'b0);
    cycle(1'b1, 56'h22FF, 1'b1, 13'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 56'h33, 1'b1, 13'h30, 1'b1, 1'b0);
    cycle(1'b1, 56'h33, 1'b1, 13'h30, 1'b0, 1'b0);
    cycle(1'b1, 56'h44, 1'b0, 13'h40, 1'b0, 1'b0);
    idle();
    idle();
    check("stream_drained", 64'(q.size()), 64'd0);

    // Flush and stall together with two ops in flight
    cycle(1'b1, 56'h55, 1'b1, 13'h50, 1'b0, 1'b0);
    cycle(1'b1, 56'h66, 1'b1, 13'h60, 1'b0, 1'b0);
    cycle(1'b1, 56'h77, 1'b1, 13'h70, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle();

    // Asynchronous reset between edges while a result is valid
    cycle(1'b1, 56'h88, 1'b1, 13'h80, 1'b0, 1'b0);
    idle();
    check("prerst_vld", 64'(o_vld), 64'd1);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_vld",  64'(o_vld),  64'd0);
    check("arst_frac", 64'(o_frac), 64'd0);
    check("arst_exp",  64'(o_exp),  64'd0);
    check("arst_ovf",  64'(o_ovf),  64'd0);
    #2;
    rst_b = 1'b1;
    q.delete();
    @(posedge nclk);
    #1;
    idle();
    cycle(1'b1, 56'h99FF, 1'b1, 13'h90, 1'b0, 1'b0);
    idle();
    check("postrst_frac", 64'(o_frac), 64'h9A00);

    // Randomized stream with occasional stall/flush and carry-heavy data
    for (int i = 0; i < 400; i++) begin
      rf = W'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) begin
        ones = '1;
        ones = ones >> $urandom_range(0, W-1);
        rf = rf | ones;
      end
      cycle($urandom_range(0, 3) != 0, rf, 1'($urandom_range(0, 1)),
            EW'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 3; i++) idle();
    check("final_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_rnd_inc.md
# fu_rnd_inc

Pipelined rounding incrementer for the FPU round stage. It takes an NB-byte fraction, a round-up decision and an exponent, and returns the rounded fraction and adjusted exponent two cycles later. The fraction is incremented per byte with `fu_loc8inc` sections, and a global carry-select combines the bytes. On mantissa overflow it renormalizes and bumps the exponent. It sits between round-decision logic (upstream) and result formatting/writeback (downstream).

## Interface
- `NB`, default 7: number of 8-bit fraction bytes; W = 8*NB (56 covers a 53-bit mantissa plus guard padding).
- `EW`, default 13: exponent width.

Ports:
- `nclk`  in  1  clock; all flops rising-edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `i_vld`  in  1  input valid.
- `i_frac`  in  [0:W-1]  fraction, bit 0 = MSB.
- `i_inc`  in  1  round-up decision; 1 = add 1 at bit W-1.
- `i_exp`  in  [0:EW-1]  exponent, bit 0 = MSB.
- `i_stall`  in  1  freeze whole pipe.
- `i_flush`  in  1  kill all in-flight ops.
- `o_vld`  out  1  result valid.
- `o_frac`  out  [0:W-1]  rounded fraction.
- `o_exp`  out  [0:EW-1]  adjusted exponent.
- `o_ovf`  out  1  increment carried out of bit 0; renormalized.

## Operation
- Stage ex1 registers: `v1`, `frac1`, `inc1`, `exp1`.
- Stage ex2 registers drive the outputs: `o_vld`, `o_frac`, `o_exp`, `o_ovf`.
- Per byte k (0..NB-1), compute from ex1 with one `fu_loc8inc` per byte: ci=1, ci_b=0.
  - s0_k = byte.
  - s1_k = byte+1 mod 256.
  - allone_k = ~co_b_k.
- Carry into byte k: c_k = inc1 & AND(allone_j, j=k+1..NB-1). c_{NB-1} = inc1.
- Result byte k = c_k ? s1_k : s0_k.
- Overflow: ovf = inc1 & AND(all allone_k). The summed fraction is then all zeros. Overwrite it with bit 0 = 1 and the rest 0, and set exp = exp1 + 1.
- Otherwise exp = exp1.
- Exponent add wraps mod 2^EW with no saturation. Range checks are downstream.
- i_inc=0 passes the fraction and exponent through unchanged, and ovf=0.
- Load rule, every edge, in priority order:
  1. `rst_b`=0 (async): all ex1/ex2 registers and outputs go to 0.
  2. `i_flush`=1: v1←0 and o_vld←0. Flush beats stall. Data registers hold.
  3. `i_stall`=1: all registers hold.
  4. Otherwise: ex1 ← inputs with v1←i_vld; ex2 ← ex1 result with o_vld←v1.
- Data registers may load while the valid bit is 0. Consumers qualify on `o_vld`.
- Input is accepted iff i_vld & ~i_stall & ~i_flush.

## Timing
- Latency 2: input accepted at edge n appears on outputs after edge n+1, with no stall.
- Throughput: 1 per cycle.
- Stall: outputs stay constant for every stalled cycle. No op is dropped or duplicated.
- Flush: o_vld=0 from the next edge. Inputs presented in the flush cycle are discarded.
- Reset mid-operation: o_vld drops immediately, asynchronously. The first valid output after release needs a new input plus 2 edges.
- Critical path: ex1 register, byte incrementers, AND tree over NB allone flags, select mux, ex2 register. This fits in one cycle.

## Structure
- Shared `fu` package holds:
  - `FU_FRAC_BYTES`=7 and `FU_EXP_W`=13 constants.
  - the overflow-renormalized fraction constant (MSB one, rest zero).
- Sub-module: `fu_loc8inc`, instantiated NB times.
- Carry-select, overflow and exponent logic stay inline. No FSM is needed beyond the valid pipeline.

## Test plan
- frac=0x00000000_0000FF, inc=1, exp=0x3FF → 2 cycles later frac=0x00000000_000100, exp=0x3FF, ovf=0, o_vld=1.
- frac=0xFFFFFFFF_FFFFFF, inc=1, exp=0x3FF → frac=0x80000000_000000, exp=0x400, ovf=1.
- exp=0x1FFF with an all-ones fraction, inc=1 → exp=0x0000, ovf=1, no X and no saturation.
- Back-to-back stream of 4 ops with `i_stall` high for 3 cycles after the second op → outputs frozen during the stall, all 4 results arrive in order, none lost or repeated.
- `i_flush` and `i_stall` both high with 2 ops in flight → o_vld=0 next cycle, and both ops are gone after release.
- `rst_b` pulsed low between edges while o_vld=1 → o_vld, o_frac, o_exp and o_ovf all 0 immediately. Normal 2-cycle latency resumes after release.
